// File: rtl/pld_registered.sv
// pld_registered: PLA-style AND/OR array with per-output macrocells
// (registered/combinational, selectable polarity) and registered feedback.
// The fuse map is loaded serially through a start/valid/data handshake.
// Optional configuration readback port: define PLD_READBACK_EN.
module pld_registered #(
    parameter  int NUM_PORTS_IN  = 2,
    parameter  int NUM_PORTS_OUT = 2,
    parameter  int NUM_TERMS     = 4,
    localparam int N             = NUM_PORTS_IN,
    localparam int M             = NUM_PORTS_OUT,
    localparam int P             = NUM_TERMS,
    localparam int L             = N + M,
    localparam int CFG_BITS      = P * 2 * L + M * P + 2 * M
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] inputs_i,
    input  logic         prog_start_i,
    input  logic         prog_valid_i,
    input  logic         prog_data_i,
    output logic         prog_done_o,
    output logic [M-1:0] outputs_o
`ifdef PLD_READBACK_EN
    ,
    input  logic [$clog2(CFG_BITS)-1:0] cfg_rd_addr_i,
    output logic                        cfg_rd_data_o
`endif
);

    localparam int CW    = $clog2(CFG_BITS + 1);
    localparam int OR_B  = P * 2 * L;
    localparam int MC_B  = P * 2 * L + M * P;

    typedef enum logic [1:0] {
        ST_UNCFG,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_clear;
    logic                w_accept;

    logic [CFG_BITS-1:0] r_cfg;
    logic [CW-1:0]       r_cnt;
    logic [M-1:0]        r_q;

    logic [L-1:0]        w_sig;
    logic [2*L-1:0]      w_lit;
    logic [P-1:0]        w_term;
    logic [M-1:0]        w_or;
    logic [M-1:0]        w_regsel;
    logic [M-1:0]        w_inv;
    logic [CFG_BITS-1:0] w_wr_sel;

    // AND-array signals: external inputs first, then macrocell feedback (never or_m)
    assign w_sig = {r_q, inputs_i};

    for (genvar j = 0; j < L; j++) begin : g_lit
        assign w_lit[2*j]   = w_sig[j];
        assign w_lit[2*j+1] = ~w_sig[j];
    end

    // A term with no connected literal evaluates 0 rather than the empty-AND 1
    for (genvar p = 0; p < P; p++) begin : g_term
        logic [2*L-1:0] w_fuse;
        assign w_fuse    = r_cfg[p*2*L +: 2*L];
        assign w_term[p] = (|w_fuse) & (&(~w_fuse | w_lit));
    end

    for (genvar m = 0; m < M; m++) begin : g_mc
        assign w_or[m]     = |(r_cfg[OR_B + m*P +: P] & w_term);
        assign w_regsel[m] = r_cfg[MC_B + 2*m];
        assign w_inv[m]    = r_cfg[MC_B + 2*m + 1];
    end

    // One-hot write strobe for the config bit addressed by the load counter
    for (genvar k = 0; k < CFG_BITS; k++) begin : g_wsel
        assign w_wr_sel[k] = (r_cnt == CW'(k));
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_UNCFG;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and load/clear control
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_UNCFG: begin
                if (prog_start_i) begin
                    w_state_next = ST_LOAD;
                    w_clear      = 1'b1;
                end
            end
            ST_LOAD: begin
                if (prog_start_i) begin
                    w_clear = 1'b1;
                end else if (prog_valid_i) begin
                    w_accept = 1'b1;
                    if (r_cnt == CW'(CFG_BITS - 1)) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (prog_start_i) begin
                    w_state_next = ST_LOAD;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_UNCFG;
            end
        endcase
    end

    // Config store, load counter and macrocell registers
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_cfg <= '0;
            r_cnt <= '0;
            r_q   <= '0;
        end else if (w_accept) begin
            r_cfg <= (r_cfg & ~w_wr_sel) | (w_wr_sel & {CFG_BITS{prog_data_i}});
            r_cnt <= r_cnt + 1'b1;
        end else if (r_state == ST_RUN) begin
            r_q <= w_or;
        end
    end

    assign prog_done_o = (r_state == ST_RUN);
    assign outputs_o   = (r_state == ST_RUN)
                       ? (((w_regsel & r_q) | (~w_regsel & w_or)) ^ w_inv)
                       : '0;

`ifdef PLD_READBACK_EN
    localparam int RD_AW = $clog2(CFG_BITS);

    logic                r_rd;
    logic [CFG_BITS-1:0] w_rd_sel;

    // Out-of-range addresses match no strobe and read back 0
    for (genvar k = 0; k < CFG_BITS; k++) begin : g_rsel
        assign w_rd_sel[k] = (cfg_rd_addr_i == RD_AW'(k));
    end

    // Registered readback of the addressed config bit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd <= 1'b0;
        end else begin
            r_rd <= |(r_cfg & w_rd_sel);
        end
    end

    assign cfg_rd_data_o = r_rd;
`endif

endmodule

// File: tb/tb_pld_registered.sv
// tb_pld_registered: randomized scoreboard bench for pld_registered
// (N=2, M=1, P=2 -> CFG_BITS=16).
module tb_pld_registered;

    localparam int N    = 2;
    localparam int M    = 1;
    localparam int P    = 2;
    localparam int L    = N + M;
    localparam int CFG  = P * 2 * L + M * P + 2 * M;
    localparam int ORB  = P * 2 * L;
    localparam int MCB  = P * 2 * L + M * P;

    localparam int unsigned XOR_CFG    = 32'h3189;
    localparam int unsigned XORINV_CFG = 32'hB189;
    localparam int unsigned TOGGLE_CFG = 32'h5020;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] inputs_i;
    logic         prog_start_i;
    logic         prog_valid_i;
    logic         prog_data_i;
    logic         prog_done_o;
    logic [M-1:0] outputs_o;

    pld_registered #(
        .NUM_PORTS_IN (N),
        .NUM_PORTS_OUT(M),
        .NUM_TERMS    (P)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inputs_i    (inputs_i),
        .prog_start_i(prog_start_i),
        .prog_valid_i(prog_valid_i),
        .prog_data_i (prog_data_i),
        .prog_done_o (prog_done_o),
        .outputs_o   (outputs_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard: expected {done, outputs} per cycle, with a label
    logic [M:0] exp_q[$];
    string      name_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    // Reference model: fuse map, feedback bits, load position, mode
    bit m_cfg[CFG];
    bit m_q[M];
    int m_cnt;
    int m_mode; // 0 unconfigured, 1 loading, 2 running

    function automatic void model_clear();
        for (int i = 0; i < CFG; i++) m_cfg[i] = 1'b0;
        for (int i = 0; i < M; i++) m_q[i] = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic bit signal_val(int j, int inv);
        if (j < N) return ((inv >> j) & 1) != 0;
        return m_q[j - N];
    endfunction

    function automatic bit or_of(int m, int inv);
        bit r;
        bit any;
        bit all;
        bit s;
        r = 1'b0;
        for (int p = 0; p < P; p++) begin
            any = 1'b0;
            all = 1'b1;
            for (int j = 0; j < L; j++) begin
                s = signal_val(j, inv);
                if (m_cfg[p*2*L + 2*j])     begin any = 1'b1; all = all & s;  end
                if (m_cfg[p*2*L + 2*j + 1]) begin any = 1'b1; all = all & !s; end
            end
            if (any && all && m_cfg[ORB + m*P + p]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [M:0] model_exp(int inv);
        int o;
        bit v;
        o = 0;
        if (m_mode == 2) begin
            for (int m = 0; m < M; m++) begin
                v = m_cfg[MCB + 2*m] ? m_q[m] : or_of(m, inv);
                v = v ^ m_cfg[MCB + 2*m + 1];
                if (v) o = o | (1 << m);
            end
        end
        return {(m_mode == 2), M'(o)};
    endfunction

    function automatic void model_step(bit rs, bit st, bit vl, bit dt, int inv);
        bit nq[M];
        if (rs) begin
            model_clear();
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (st) begin model_clear(); m_mode = 1; end
                1: begin
                    if (st) begin
                        model_clear();
                    end else if (vl) begin
                        m_cfg[m_cnt] = dt;
                        m_cnt++;
                        if (m_cnt == CFG) m_mode = 2;
                    end
                end
                default: begin
                    if (st) begin
                        model_clear();
                        m_mode = 1;
                    end else begin
                        for (int m = 0; m < M; m++) nq[m] = or_of(m, inv);
                        for (int m = 0; m < M; m++) m_q[m] = nq[m];
                    end
                end
            endcase
        end
    endfunction

    // One clock of stimulus: drive, queue the expectation, advance the model
    task automatic step(input bit rs, input bit st, input bit vl, input bit dt,
                        input int inv, input string nm,
                        input bit use_c, input logic [M:0] c_exp);
        rst_i        = rs;
        prog_start_i = st;
        prog_valid_i = vl;
        prog_data_i  = dt;
        inputs_i     = N'(inv);
        if (use_c) exp_q.push_back(c_exp);
        else       exp_q.push_back(model_exp(inv));
        name_q.push_back(nm);
        @(posedge clk_i);
        model_step(rs, st, vl, dt, inv);
        #1;
    endtask

    // Serial load of the first nbits of a fuse map with random stall gaps
    task automatic load_stream(input int unsigned bits, input int nbits,
                               input int gap_pct, input bit do_start);
        if (do_start)
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), "load_start", 1'b0, '0);
        for (int k = 0; k < nbits; k++) begin
            while (int'($urandom_range(0, 99)) < gap_pct)
                step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), "load_stall", 1'b1, '0);
            step(1'b0, 1'b0, 1'b1, ((bits >> k) & 1) != 0,
                 int'($urandom_range(0, 3)), "load_bit", 1'b1, '0);
        end
    endtask

    // Two-input XOR truth table, optionally inverted
    task automatic check_xor(input bit inv_pol, input string nm);
        int v;
        for (int i = 0; i < 4; i++) begin
            v = (i ^ (i >> 1)) & 1;
            if (inv_pol) v = v ^ 1;
            step(1'b0, 1'b0, 1'b0, 1'b0, i, nm, 1'b1, {1'b1, M'(v)});
        end
    endtask

    logic [M:0] mon_e;
    string      mon_n;

    // Monitor: every cycle with a queued expectation, compare mid-cycle
    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                n_cmp++;
                if ({prog_done_o, outputs_o} !== mon_e) begin
                    n_err++;
                    $display("FAIL %s: got done=%0b out=%b, expected done=%0b out=%b",
                             mon_n, prog_done_o, outputs_o, mon_e[M], mon_e[M-1:0]);
                end
            end
        end
    end

    initial begin
        int r;
        rst_i        = 1'b1;
        prog_start_i = 1'b0;
        prog_valid_i = 1'b0;
        prog_data_i  = 1'b0;
        inputs_i     = '0;
        repeat (2) @(posedge clk_i);
        model_clear();
        m_mode = 0;
        #1;

        // Reset state, idle with toggling inputs
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, i % 4, "reset_idle", 1'b1, '0);

        // XOR, combinational
        load_stream(XOR_CFG, CFG, 0, 1'b1);
        check_xor(1'b0, "xor");

        // XOR with inverted output
        load_stream(XORINV_CFG, CFG, 0, 1'b1);
        check_xor(1'b1, "xor_inv");

        // Toggle flop through registered feedback, then restart mid-run
        load_stream(TOGGLE_CFG, CFG, 0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 3)), "toggle",
                 1'b1, {1'b1, M'(i % 2)});
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, "toggle_restart", 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "after_restart", 1'b1, '0);

        // Stalled load aborted after 7 bits, restart with a discarded valid bit
        load_stream(XOR_CFG, 7, 40, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 0, "restart_discard", 1'b1, '0);
        load_stream(XOR_CFG, CFG, 40, 1'b0);
        check_xor(1'b0, "xor_after_restart");

        // Random fuse maps, random run traffic including starts and resets
        for (int round = 0; round < 30; round++) begin
            load_stream($urandom() & 32'hFFFF, CFG, 25, 1'b1);
            for (int c = 0; c < 12; c++) begin
                r = int'($urandom_range(0, 39));
                step(r == 0, r == 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), "random_run", 1'b0, '0);
            end
        end

        repeat (3) @(posedge clk_i);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
